// File: rtl/multicycle_ctrl_if.sv
// Control bundle between multicycle_ctrl and the datapath it drives.
// master: the control unit (receives op/func, drives control levels and strobes).
// slave:  the datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned RETIRE_W = 16
);
  logic [2:0]          op;
  logic [2:0]          func;
  logic                IRWr;
  logic                PCWr;
  logic                Branch;
  logic                Jump;
  logic                RegDst;
  logic                ALUSrc;
  logic                MemtoReg;
  logic                RegWr;
  logic                MemWr;
  logic                ExtOp;
  logic [2:0]          ALUctr;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  op, func,
    output IRWr, PCWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp,
    output ALUctr, halted, illegal, retired
  );

  modport slave (
    output op, func,
    input  IRWr, PCWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp,
    input  ALUctr, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: IF/ID/EX/MEM/WB/HALT Moore machine that sequences
// each instruction over 2-5 cycles and drives the datapath control levels.
// Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN -- when defined, an
// illegal R-type func traps to HALT and sets the sticky 'illegal' flag; when
// undefined, an illegal func retires as a NOP from ID.
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W = 16
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_if.master  bus
);

  localparam logic [2:0] OpR     = 3'b000;
  localparam logic [2:0] OpOri   = 3'b001;
  localparam logic [2:0] OpAddiu = 3'b010;
  localparam logic [2:0] OpLw    = 3'b011;
  localparam logic [2:0] OpSw    = 3'b100;
  localparam logic [2:0] OpBeq   = 3'b101;
  localparam logic [2:0] OpJ     = 3'b110;
  localparam logic [2:0] OpHalt  = 3'b111;

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, func_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                func_bad;

  // Ungated combinational outputs; reset masking is applied at the ports.
  logic       irwr, pcwr, branch, jump, regdst, alusrc, memtoreg, regwr, memwr, extop;
  logic [2:0] aluctr;

  // EX-phase levels derived from the latched decode, held through MEM and WB.
  logic       alusrc_ex, extop_ex;
  logic [2:0] aluctr_ex;

  assign func_bad = (bus.func > 3'd4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIf;
    else     state_q <= state_d;
  end

  // Decode capture on the edge leaving ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 3'b000;
      func_q <= 3'b000;
    end else if (state_q == StId) begin
      op_q   <= bus.op;
      func_q <= bus.func;
    end
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf: state_d = StId;
      StId: begin
        unique case (bus.op)
          OpR: begin
            if (func_bad) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
              state_d = StHalt;
`else
              state_d = StIf;
`endif
            end else begin
              state_d = StEx;
            end
          end
          OpJ:     state_d = StIf;
          OpHalt:  state_d = StHalt;
          default: state_d = StEx;
        endcase
      end
      StEx: begin
        unique case (op_q)
          OpLw, OpSw: state_d = StMem;
          OpBeq:      state_d = StIf;
          default:    state_d = StWb;
        endcase
      end
      StMem:   state_d = (op_q == OpLw) ? StWb : StIf;
      StWb:    state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // ALU/immediate levels selected by the latched opcode.
  always_comb begin
    alusrc_ex = 1'b0;
    extop_ex  = 1'b0;
    aluctr_ex = 3'b000;
    unique case (op_q)
      OpR:              aluctr_ex = func_q;
      OpOri:   begin alusrc_ex = 1'b1; aluctr_ex = 3'b011; end
      OpAddiu, OpLw, OpSw: begin alusrc_ex = 1'b1; extop_ex = 1'b1; end
      OpBeq:            aluctr_ex = 3'b001;
      default: ;
    endcase
  end

  // Moore outputs per state.
  always_comb begin
    irwr     = 1'b0;
    pcwr     = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    regwr    = 1'b0;
    memwr    = 1'b0;
    extop    = 1'b0;
    aluctr   = 3'b000;
    unique case (state_q)
      StIf: irwr = 1'b1;
      StId: begin
        if (bus.op == OpJ) begin
          jump = 1'b1;
          pcwr = 1'b1;
        end
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        // Illegal func retires as a NOP straight out of ID.
        if (bus.op == OpR && func_bad) pcwr = 1'b1;
`endif
      end
      StEx: begin
        alusrc = alusrc_ex;
        extop  = extop_ex;
        aluctr = aluctr_ex;
        if (op_q == OpBeq) begin
          branch = 1'b1;
          pcwr   = 1'b1;
        end
      end
      StMem: begin
        alusrc = alusrc_ex;
        extop  = extop_ex;
        aluctr = aluctr_ex;
        if (op_q == OpSw) begin
          memwr = 1'b1;
          pcwr  = 1'b1;
        end
      end
      StWb: begin
        alusrc   = alusrc_ex;
        extop    = extop_ex;
        aluctr   = aluctr_ex;
        regwr    = 1'b1;
        pcwr     = 1'b1;
        regdst   = (op_q == OpR);
        memtoreg = (op_q == OpLw);
      end
      default: ;
    endcase
  end

  // Retired-instruction counter, one per PC update, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       retired_q <= '0;
    else if (pcwr) retired_q <= retired_q + 1'b1;
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal flag, set on the ID edge that traps to HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  illegal_q <= 1'b0;
    else if (state_q == StId && bus.op == OpR && func_bad)    illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  // Every output is forced low while reset is asserted.
  assign bus.IRWr     = irwr     & ~rst;
  assign bus.PCWr     = pcwr     & ~rst;
  assign bus.Branch   = branch   & ~rst;
  assign bus.Jump     = jump     & ~rst;
  assign bus.RegDst   = regdst   & ~rst;
  assign bus.ALUSrc   = alusrc   & ~rst;
  assign bus.MemtoReg = memtoreg & ~rst;
  assign bus.RegWr    = regwr    & ~rst;
  assign bus.MemWr    = memwr    & ~rst;
  assign bus.ExtOp    = extop    & ~rst;
  assign bus.ALUctr   = aluctr   & {3{~rst}};
  assign bus.halted   = (state_q == StHalt) & ~rst;
  assign bus.retired  = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit driving the `DataPath` control inputs (`Branch`, `Jump`, `RegDst`, `ALUSrc`, `MemtoReg`, `RegWr`, `MemWr`, `ExtOp`, `ALUctr`) from the `op`/`func` fields the datapath returns. A state machine (IF/ID/EX/MEM/WB/HALT) sequences each instruction over 2–5 cycles. It emits PC and IR write strobes and keeps a count of retired instructions. It replaces hand-driven control levels in datapath benches.

## Interface
- `RETIRE_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  3  opcode from the datapath IR.
- `func`  in  3  R-type function field from the datapath IR.
- `IRWr`  out  1  IR load strobe.
- `PCWr`  out  1  PC update strobe, high in the final cycle of each instruction.
- `Branch`, `Jump`, `RegDst`, `ALUSrc`, `MemtoReg`, `ExtOp`  out  1 each  datapath control levels.
- `RegWr`, `MemWr`  out  1 each  write strobes.
- `ALUctr`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  sticky illegal-instruction flag (see Configuration).
- `retired`  out  RETIRE_W  count of completed instructions.

## Operation
- Opcodes:
  - 000 R-type: `ALUctr`=`func` for `func` 000–100; `func` 101–111 is illegal.
  - 001 ori: ExtOp=0, ALUctr=011.
  - 010 addiu: ExtOp=1, ALUctr=000.
  - 011 lw.
  - 100 sw.
  - 101 beq.
  - 110 j.
  - 111 halt.
- State sequences:
  - R/ori/addiu: IF→ID→EX→WB.
  - lw: IF→ID→EX→MEM→WB.
  - sw: IF→ID→EX→MEM.
  - beq: IF→ID→EX.
  - j: IF→ID.
  - halt: IF→ID→HALT. HALT is terminal until reset.
- The last state of each sequence returns to IF.
- Decode capture: `op`/`func` are latched on the clock edge that leaves ID. All level outputs come from the latched copy in EX, MEM and WB.
- Outputs by state:
  - IF: IRWr=1; all other controls 0.
  - ID: decode only. For j, assert Jump=1 and PCWr=1.
  - EX:
    - ALUSrc=1 and ExtOp=1 for lw/sw/addiu; ALUSrc=1 and ExtOp=0 for ori.
    - ALUctr per opcode; lw/sw/addiu use 000.
    - beq: ALUctr=001, Branch=1, PCWr=1.
  - MEM: lw holds its EX levels. sw holds its EX levels and asserts MemWr=1 and PCWr=1.
  - WB:
    - RegWr=1 and PCWr=1.
    - R-type: RegDst=1, MemtoReg=0.
    - ori/addiu: RegDst=0, MemtoReg=0.
    - lw: RegDst=0, MemtoReg=1.
    - ALUSrc, ExtOp and ALUctr hold their EX values.
- Strobe rule: RegWr, MemWr, IRWr and PCWr are single-cycle pulses and never assert in the same cycle as `rst`.
- `retired` increments on every cycle with PCWr=1 and wraps from all-ones to 0. The halt instruction does not increment it.
- Reset: every output goes to 0 and the state to IF. Reset mid-instruction abandons that instruction with no strobe.

## Timing
- Registered-state Moore machine. Outputs are combinational from the state plus the latched decode, and are glitch-free relative to `clk`.
- CPI:
  - j: 2.
  - beq: 3.
  - R, ori, addiu, sw: 4.
  - lw: 5.
- The first IRWr is in the first cycle after `rst` deasserts.
- `halted` rises in the cycle after the ID of a halt instruction.
- `op`/`func` must be stable from the edge ending IF through the edge ending ID.

## Configuration
- `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal R-type `func` in ID transitions to HALT.
  - `illegal` is set there and held until reset.
  - No PCWr, no retire.
- Undefined:
  - An illegal `func` is a NOP: ID asserts PCWr=1 and returns to IF, with `retired` +1.
  - `illegal` is tied 0.

## Test plan
- Reset mid-WB of an add: assert `rst` with RegWr=1 → all outputs 0 immediately; the first cycle after release is IF with IRWr=1 and `retired`=0.
- add (op=000, func=000) → IRWr, then an idle ID, then EX with ALUctr=000, then WB with RegDst=1, RegWr=1, PCWr=1; 4 cycles; `retired` 0→1.
- lw then sw:
  - lw takes 5 cycles with MemtoReg=1 and RegWr=1 only in WB.
  - sw takes 4 cycles with MemWr=1 only in MEM; RegWr is never high.
  - `retired`=2.
- Control flow:
  - beq: Branch=1, ALUctr=001, PCWr=1 in cycle 3.
  - j: Jump=1 and PCWr=1 in cycle 2.
  - `retired`=2 after the pair.
- Halt and wrap:
  - With RETIRE_W=4, run 16 j instructions → `retired` wraps to 0.
  - Then op=111 → `halted`=1 and no further IRWr for 20 cycles.
- Illegal func=110:
  - With the macro: `halted`=1, `illegal`=1, `retired` unchanged.
  - Without the macro: PCWr in cycle 2, `retired` +1, `illegal`=0.
